// File: rtl/booth_mult_arbiter.sv
// booth_mult_arbiter: round-robin front end that shares one Booth multiplier
// among N_REQ requesters. Each grant runs a clear/load/iterate/capture
// sequence and then holds the product until the consumer accepts it.
module booth_mult_arbiter #(
  parameter int N_REQ      = 4,
  parameter int RUN_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [4*N_REQ-1:0]   req_m,
  input  logic [4*N_REQ-1:0]   req_q,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [7:0]           resp_p,
  output logic [2:0]           resp_id,
  output logic                 busy,
  output logic                 mult_reset,
  output logic                 mult_load,
  output logic [3:0]           mult_m,
  output logic [3:0]           mult_q,
  input  logic [7:0]           mult_p
);

  localparam int unsigned NU = N_REQ;
  localparam int          CW = $clog2(RUN_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, CLR, LOAD, RUN, CAPT, RESP} state_t;

  state_t           state, state_nx;
  logic [2:0]       last_grant;
  logic [CW-1:0]    run_cnt;
  logic [3:0]       cap_m, cap_q;
  logic [2:0]       cap_id;

  logic             grant_any;
  logic [N_REQ-1:0] grant_vec;
  logic [2:0]       grant_idx;
  logic [3:0]       grant_m, grant_q;
  int unsigned      lg;

  // Round-robin pick: two passes, first above last_grant, then wrapping to 0
  always_comb begin
    grant_any = 1'b0;
    grant_vec = '0;
    grant_idx = '0;
    grant_m   = '0;
    grant_q   = '0;
    lg        = 32'(last_grant);
    for (int unsigned i = 0; i < NU; i++) begin
      if (!grant_any && req_valid[i] && (i > lg)) begin
        grant_any    = 1'b1;
        grant_vec[i] = 1'b1;
        grant_idx    = 3'(i);
        grant_m      = req_m[4*i +: 4];
        grant_q      = req_q[4*i +: 4];
      end
    end
    for (int unsigned i = 0; i < NU; i++) begin
      if (!grant_any && req_valid[i] && (i <= lg)) begin
        grant_any    = 1'b1;
        grant_vec[i] = 1'b1;
        grant_idx    = 3'(i);
        grant_m      = req_m[4*i +: 4];
        grant_q      = req_q[4*i +: 4];
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (grant_any) state_nx = CLR;
      CLR:     state_nx = LOAD;
      LOAD:    state_nx = RUN;
      RUN:     if (run_cnt == CW'(1)) state_nx = CAPT;
      CAPT:    state_nx = RESP;
      RESP:    if (resp_valid && resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decoded from state; reset forces the multiplier into clear
  always_comb begin
    req_ready  = (state == IDLE && !reset) ? grant_vec : '0;
    mult_reset = reset || (state == CLR);
    mult_load  = !reset && (state == LOAD);
    busy       = !reset && (state != IDLE);
  end

  assign mult_m = cap_m;
  assign mult_q = cap_q;

  // Operand capture, iteration counter and response registers
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 3'(N_REQ - 1);
      cap_m      <= '0;
      cap_q      <= '0;
      cap_id     <= '0;
      run_cnt    <= '0;
      resp_valid <= 1'b0;
      resp_p     <= '0;
      resp_id    <= '0;
    end else begin
      case (state)
        IDLE: if (grant_any) begin
          last_grant <= grant_idx;
          cap_m      <= grant_m;
          cap_q      <= grant_q;
          cap_id     <= grant_idx;
        end
        LOAD: run_cnt <= CW'(RUN_CYCLES);
        RUN:  run_cnt <= run_cnt - CW'(1);
        CAPT: begin
          resp_p     <= mult_p;
          resp_id    <= cap_id;
          resp_valid <= 1'b1;
        end
        RESP: if (resp_ready) resp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Directed bench for booth_mult_arbiter with a behavioural multiplier that
// only presents its product after the full iteration count.
module tb_booth_mult_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [15:0] req_m, req_q;
  logic [3:0]  req_ready;
  logic        resp_valid, resp_ready;
  logic [7:0]  resp_p;
  logic [2:0]  resp_id;
  logic        busy, mult_reset, mult_load;
  logic [3:0]  mult_m, mult_q;
  logic [7:0]  mult_p;

  int checks = 0;
  int errors = 0;
  int n_load = 0, n_clr = 0, n_grant = 0;

  booth_mult_arbiter #(.N_REQ(4), .RUN_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_m(req_m), .req_q(req_q),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_p(resp_p), .resp_id(resp_id), .busy(busy), .mult_reset(mult_reset),
    .mult_load(mult_load), .mult_m(mult_m), .mult_q(mult_q), .mult_p(mult_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] prod(input logic [3:0] a, input logic [3:0] b);
    logic signed [7:0] sa, sb;
    sa = {{4{a[3]}}, a};
    sb = {{4{b[3]}}, b};
    return 8'(sa * sb);
  endfunction

  // Multiplier model: product appears only after four iteration cycles
  logic [7:0]  mp, acc;
  int unsigned mcnt;
  always @(posedge clk) begin
    if (mult_reset) begin
      mp <= '0; mcnt <= 99;
    end else if (mult_load) begin
      mp <= '0; acc <= prod(mult_m, mult_q); mcnt <= 0;
    end else if (mcnt < 4) begin
      mcnt <= mcnt + 1;
      if (mcnt == 3) mp <= acc;
    end
  end
  assign mult_p = mp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Protocol monitor
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (mult_load && mult_reset) begin
        errors++;
        $display("FAIL load_reset_overlap: actual=%b%b required=not both", mult_load, mult_reset);
      end
      checks++;
      if (!$onehot0(req_ready)) begin
        errors++;
        $display("FAIL ready_onehot: actual=%b required=at most one bit", req_ready);
      end
      if (mult_load) n_load++;
      if (mult_reset) n_clr++;
      if (req_ready != '0) n_grant++;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int unsigned i, input logic [3:0] m, input logic [3:0] q);
    req_m[4*i +: 4] = m;
    req_q[4*i +: 4] = q;
  endtask

  task automatic wait_grant(input logic [3:0] exp_vec, input string name, output int waited);
    waited = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        waited = i;
        break;
      end
      tick();
    end
    chk(name, 32'(req_ready), 32'(exp_vec));
  endtask

  // From the grant cycle's negedge: count cycles until resp_valid
  task automatic wait_resp(input logic [3:0] nv, output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 1) req_valid = nv;
      @(negedge clk);
      if (resp_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  typedef struct {
    int unsigned idx;
    logic [3:0]  m;
    logic [3:0]  q;
    logic [7:0]  p;
  } vec_t;

  vec_t vecs[8];
  logic [7:0] rr_p[4];

  initial begin
    int w, lat, ng, nr, seen;
    int unsigned g_cyc[5];
    int unsigned g_id[5];
    logic [2:0]  r_id[5];
    logic [7:0]  r_p[5];

    vecs[0] = '{0, 4'h3, 4'h5, 8'h0F};
    vecs[1] = '{1, 4'hD, 4'h5, 8'hF1};
    vecs[2] = '{2, 4'h7, 4'hE, 8'hF2};
    vecs[3] = '{3, 4'hC, 4'hC, 8'h10};
    vecs[4] = '{0, 4'h7, 4'h7, 8'h31};
    vecs[5] = '{1, 4'h0, 4'h9, 8'h00};
    vecs[6] = '{2, 4'hF, 4'hF, 8'h01};
    vecs[7] = '{3, 4'h2, 4'h8, 8'hF0};
    rr_p[0] = 8'h06; rr_p[1] = 8'hF1; rr_p[2] = 8'hEE; rr_p[3] = 8'h31;

    reset = 1'b1; resp_ready = 1'b1;
    req_m = '0; req_q = '0;
    set_op(0, 4'h3, 4'h5);
    req_valid = 4'b0001;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_p", 32'(resp_p), 0);
    chk("rst_resp_id", 32'(resp_id), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mult_load", 32'(mult_load), 0);
    chk("rst_mult_reset", 32'(mult_reset), 1);
    chk("rst_mult_m", 32'(mult_m), 0);
    chk("rst_mult_q", 32'(mult_q), 0);
    tick();
    reset = 1'b0;

    // Table-driven single requests, consumer always ready
    for (int i = 0; i < 8; i++) begin
      if (i > 0) tick();
      req_m = '0; req_q = '0;
      set_op(vecs[i].idx, vecs[i].m, vecs[i].q);
      req_valid = 4'(1 << vecs[i].idx);
      wait_grant(4'(1 << vecs[i].idx), "vec_grant", w);
      if (i == 0) chk("first_grant_after_reset", 32'(w), 0);
      wait_resp(4'b0000, lat);
      chk("vec_latency", 32'(lat), 8);
      chk("vec_resp_p", 32'(resp_p), 32'(vecs[i].p));
      chk("vec_resp_id", 32'(resp_id), vecs[i].idx);
      chk("vec_busy", 32'(busy), 1);
      chk("vec_mult_m_hold", 32'(mult_m), 32'(vecs[i].m));
      chk("vec_mult_q_hold", 32'(mult_q), 32'(vecs[i].q));
    end

    // Round-robin with all four requesting continuously
    tick(); reset = 1'b1; req_valid = '0;
    tick(); reset = 1'b0;
    set_op(0, 4'h2, 4'h3); set_op(1, 4'hB, 4'h3);
    set_op(2, 4'h6, 4'hD); set_op(3, 4'h9, 4'h9);
    req_valid = 4'hF;
    ng = 0; nr = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (req_ready != '0 && ng < 5) begin
        g_cyc[ng] = c;
        g_id[ng] = 99;
        for (int j = 0; j < 4; j++) if (req_ready[j]) g_id[ng] = j;
        ng++;
      end
      if (resp_valid && nr < 5) begin
        r_id[nr] = resp_id; r_p[nr] = resp_p; nr++;
      end
      if (nr == 5) break;
      tick();
    end
    tick(); req_valid = '0;
    chk("rr_grant_count", 32'(ng), 5);
    chk("rr_resp_count", 32'(nr), 5);
    if (ng == 5 && nr == 5) begin
      chk("rr_first_grant_cycle", g_cyc[0], 0);
      for (int k = 0; k < 5; k++) begin
        chk("rr_grant_id", g_id[k], 32'(k % 4));
        chk("rr_resp_id", 32'(r_id[k]), 32'(k % 4));
        chk("rr_resp_p", 32'(r_p[k]), 32'(rr_p[k % 4]));
        if (k > 0) chk("rr_spacing", g_cyc[k] - g_cyc[k-1], 9);
      end
    end

    // Backpressure: req3 waits while req1's product is held
    set_op(1, 4'h5, 4'h5); set_op(3, 4'hE, 4'h6);
    resp_ready = 1'b0;
    req_valid = 4'b0010;
    wait_grant(4'b0010, "bp_grant", w);
    wait_resp(4'b1000, lat);
    chk("bp_latency", 32'(lat), 8);
    for (int i = 0; i < 10; i++) begin
      chk("bp_resp_valid", 32'(resp_valid), 1);
      chk("bp_resp_p", 32'(resp_p), 32'h19);
      chk("bp_resp_id", 32'(resp_id), 1);
      chk("bp_busy", 32'(busy), 1);
      chk("bp_no_grant", 32'(req_ready), 0);
      if (i < 9) begin tick(); @(negedge clk); end
    end
    tick(); resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_handshake_valid", 32'(resp_valid), 1);
    chk("bp_handshake_no_grant", 32'(req_ready), 0);
    tick();
    @(negedge clk);
    chk("bp_next_grant", 32'(req_ready), 32'h8);
    chk("bp_valid_cleared", 32'(resp_valid), 0);
    wait_resp(4'b0000, lat);
    chk("bp2_latency", 32'(lat), 8);
    chk("bp2_resp_p", 32'(resp_p), 32'hF4);
    chk("bp2_resp_id", 32'(resp_id), 3);

    // Reset pulsed while the multiplier is iterating
    tick();
    set_op(2, 4'h3, 4'h3);
    req_valid = 4'b0100;
    wait_grant(4'b0100, "abort_grant", w);
    tick(); req_valid = '0; @(negedge clk);
    tick(); @(negedge clk);
    tick(); @(negedge clk);
    tick(); reset = 1'b1; @(negedge clk);
    chk("abort_mult_reset", 32'(mult_reset), 1);
    chk("abort_mult_load", 32'(mult_load), 0);
    chk("abort_req_ready", 32'(req_ready), 0);
    tick(); reset = 1'b0; @(negedge clk);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_resp_valid", 32'(resp_valid), 0);
    chk("abort_resp_p", 32'(resp_p), 0);
    chk("abort_resp_id", 32'(resp_id), 0);
    chk("abort_mult_m", 32'(mult_m), 0);
    chk("abort_mult_q", 32'(mult_q), 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick(); @(negedge clk);
      if (resp_valid) seen++;
    end
    chk("abort_no_response", 32'(seen), 0);
    tick();
    set_op(0, 4'hD, 4'hB);
    req_valid = 4'b0001;
    wait_grant(4'b0001, "post_abort_grant", w);
    wait_resp(4'b0000, lat);
    chk("post_abort_latency", 32'(lat), 8);
    chk("post_abort_resp_p", 32'(resp_p), 32'h0F);
    chk("post_abort_resp_id", 32'(resp_id), 0);

    tick();
    chk("grant_total", 32'(n_grant), 17);
    chk("load_per_grant", 32'(n_load), 32'(n_grant));
    chk("clr_per_grant", 32'(n_clr), 32'(n_grant));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
